recepcao_serial_comandos: RTL and testbench

- Asynchronous serial receiver for the snake game: the inbound counterpart of the serial transmission path.
- Deserialises frames sent by the host PC and checks parity and stop bits.
- Decodes ASCII command characters into game-control pulses (start, restart), a pause level and a direction register.
- Outputs feed the main control unit alongside the physical buttons and ultrasonic direction inputs.

---
 rtl/sga_serial_pkg.sv | 40 ++++
 rtl/recepcao_serial_tick.sv | 29 ++
 rtl/recepcao_serial_comandos.sv | 148 ++++++++++++++
 tb/tb_recepcao_serial_comandos.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sga_serial_pkg.sv
// Shared constants for the snake game serial link: FSM state codes,
// command characters, direction encodings and frame layout.
package sga_serial_pkg;

  localparam int   N_DATA      = 7;
  localparam int   N_STOP      = 2;
  localparam logic PARITY_EVEN = 1'b0;

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    INICIO      = 3'd1,
    DADOS       = 3'd2,
    PARIDADE    = 3'd3,
    PARADA1     = 3'd4,
    PARADA2     = 3'd5,
    ENTREGA     = 3'd6,
    ERRO_QUADRO = 3'd7
  } estado_t;

  typedef enum logic [1:0] {
    DIR_W = 2'b00,
    DIR_A = 2'b01,
    DIR_S = 2'b10,
    DIR_D = 2'b11
  } direcao_t;

  localparam logic [N_DATA-1:0] CH_START   = 7'h49;  // 'I'
  localparam logic [N_DATA-1:0] CH_RESTART = 7'h52;  // 'R'
  localparam logic [N_DATA-1:0] CH_PAUSE   = 7'h50;  // 'P'
  localparam logic [N_DATA-1:0] CH_W       = 7'h77;
  localparam logic [N_DATA-1:0] CH_A       = 7'h61;
  localparam logic [N_DATA-1:0] CH_S       = 7'h73;
  localparam logic [N_DATA-1:0] CH_D       = 7'h64;

  // True when data bits plus parity bit satisfy even parity.
  function automatic logic paridade_ok(input logic [N_DATA-1:0] d, input logic p);
    return ((^d) ^ p) == PARITY_EVEN;
  endfunction

endpackage

// File: rtl/recepcao_serial_tick.sv
// Bit-period timer: free-running 0..CLKS_PER_BIT-1 counter with a clear,
// flagging the half-period point and the last cycle of the period.
module recepcao_serial_tick
  #(parameter int CLKS_PER_BIT = 434)
  (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    output logic meio_bit,
    output logic fim_bit
  );

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] MEIO = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FIM  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Count cycles within a bit period; wrap at the end, restart on clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   cnt <= '0;
    else if (limpa || cnt == FIM) cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  assign meio_bit = (cnt == MEIO);
  assign fim_bit  = (cnt == FIM);

endmodule

// File: rtl/recepcao_serial_comandos.sv
// Serial command receiver: 7E2 frames from the host PC, parity/stop checks
// and decoding of game commands into pulses, a pause level and a direction.
module recepcao_serial_comandos
  import sga_serial_pkg::*;
  #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
  )
  (
    input  logic              clock,
    input  logic              reset,
    input  logic              entrada_serial,
    output logic [N_DATA-1:0] dado,
    output logic              pronto,
    output logic              erro_paridade,
    output logic              erro_parada,
    output logic              cmd_start,
    output logic              cmd_restart,
    output logic              pause,
    output logic [1:0]        direction,
    output logic              direction_valid,
    output logic              cmd_invalido,
    output logic [3:0]        db_state
  );

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sin;
  logic                   limpa;
  logic                   meio_bit;
  logic                   fim_bit;
  estado_t                estado;
  logic [2:0]             bit_cnt;
  logic [N_DATA-1:0]      shift;
  logic                   par_ok;

  // Synchronise the RX line; flops idle high like the line itself.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], entrada_serial};
  end

  assign sin = sync_q[SYNC_STAGES-1];

  recepcao_serial_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clock    (clock),
    .reset    (reset),
    .limpa    (limpa),
    .meio_bit (meio_bit),
    .fim_bit  (fim_bit)
  );

  // Timer alignment: held clear while idle, realigned at mid start bit so
  // later samples land on fim_bit, and held clear while a break keeps sin low.
  always_comb begin
    limpa = 1'b0;
    case (estado)
      OCIOSO:      limpa = 1'b1;
      INICIO:      limpa = meio_bit;
      ERRO_QUADRO: limpa = ~sin;
      default:     limpa = 1'b0;
    endcase
  end

  // Receive FSM, shift register and command decoder with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado          <= OCIOSO;
      bit_cnt         <= '0;
      shift           <= '0;
      par_ok          <= 1'b0;
      dado            <= '0;
      pronto          <= 1'b0;
      erro_paridade   <= 1'b0;
      erro_parada     <= 1'b0;
      cmd_start       <= 1'b0;
      cmd_restart     <= 1'b0;
      pause           <= 1'b0;
      direction       <= DIR_W;
      direction_valid <= 1'b0;
      cmd_invalido    <= 1'b0;
    end else begin
      pronto          <= 1'b0;
      erro_paridade   <= 1'b0;
      erro_parada     <= 1'b0;
      cmd_start       <= 1'b0;
      cmd_restart     <= 1'b0;
      direction_valid <= 1'b0;
      cmd_invalido    <= 1'b0;
      case (estado)
        OCIOSO: if (!sin) estado <= INICIO;
        INICIO: if (meio_bit) begin
          if (sin) estado <= OCIOSO;
          else begin
            estado  <= DADOS;
            bit_cnt <= '0;
          end
        end
        DADOS: if (fim_bit) begin
          shift <= {sin, shift[N_DATA-1:1]};
          if (bit_cnt == 3'(N_DATA - 1)) estado <= PARIDADE;
          else                           bit_cnt <= bit_cnt + 1'b1;
        end
        PARIDADE: if (fim_bit) begin
          par_ok <= paridade_ok(shift, sin);
          estado <= PARADA1;
        end
        PARADA1: if (fim_bit) begin
          if (sin) estado <= PARADA2;
          else begin
            estado      <= ERRO_QUADRO;
            erro_parada <= 1'b1;
          end
        end
        // Delivery is registered on the second stop-bit sample so the
        // pulses coincide with the single ENTREGA cycle.
        PARADA2: if (fim_bit) begin
          if (!sin) begin
            estado      <= ERRO_QUADRO;
            erro_parada <= 1'b1;
          end else begin
            estado <= ENTREGA;
            if (!par_ok) erro_paridade <= 1'b1;
            else begin
              dado   <= shift;
              pronto <= 1'b1;
              case (shift)
                CH_START:   cmd_start   <= 1'b1;
                CH_RESTART: cmd_restart <= 1'b1;
                CH_PAUSE:   pause       <= ~pause;
                CH_W: begin direction <= DIR_W; direction_valid <= 1'b1; end
                CH_A: begin direction <= DIR_A; direction_valid <= 1'b1; end
                CH_S: begin direction <= DIR_S; direction_valid <= 1'b1; end
                CH_D: begin direction <= DIR_D; direction_valid <= 1'b1; end
                default:    cmd_invalido <= 1'b1;
              endcase
            end
          end
        end
        ENTREGA:     estado <= OCIOSO;
        ERRO_QUADRO: if (sin && fim_bit) estado <= OCIOSO;
        default:     estado <= OCIOSO;
      endcase
    end
  end

  assign db_state = {1'b0, estado};

endmodule

// File: tb/tb_recepcao_serial_comandos.sv
// Bench for the serial command receiver: directed frames plus randomized
// characters, gaps and parity faults, checked against a character-level model.
module tb_recepcao_serial_comandos;

  localparam int CPB = 434;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       entrada_serial = 1'b1;
  logic [6:0] dado;
  logic       pronto, erro_paridade, erro_parada, cmd_start, cmd_restart;
  logic       pause, direction_valid, cmd_invalido;
  logic [1:0] direction;
  logic [3:0] db_state;

  always #10 clock = ~clock;

  recepcao_serial_comandos #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .entrada_serial  (entrada_serial),
    .dado            (dado),
    .pronto          (pronto),
    .erro_paridade   (erro_paridade),
    .erro_parada     (erro_parada),
    .cmd_start       (cmd_start),
    .cmd_restart     (cmd_restart),
    .pause           (pause),
    .direction       (direction),
    .direction_valid (direction_valid),
    .cmd_invalido    (cmd_invalido),
    .db_state        (db_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Pulse counters: 0 pronto, 1 erro_paridade, 2 erro_parada, 3 cmd_start,
  // 4 cmd_restart, 5 direction_valid, 6 cmd_invalido.
  string      nm[7] = '{"pronto", "erro_paridade", "erro_parada", "cmd_start",
                        "cmd_restart", "direction_valid", "cmd_invalido"};
  int         cnt[7] = '{0, 0, 0, 0, 0, 0, 0};
  int         n_wide = 0;
  logic [6:0] prev_p = '0;

  always @(negedge clock) begin
    logic [6:0] p;
    p = {cmd_invalido, direction_valid, cmd_restart, cmd_start,
         erro_parada, erro_paridade, pronto};
    for (int k = 0; k < 7; k++) begin
      cnt[k] += int'(p[k]);
      if (p[k] && prev_p[k]) n_wide++;
    end
    prev_p = p;
  end

  // Character-level model of the visible state.
  logic [6:0] m_dado  = '0;
  logic [1:0] m_dir   = '0;
  logic       m_pause = 1'b0;

  function automatic int dir_of(input logic [6:0] c);
    case (c)
      7'h77:   return 0;
      7'h61:   return 1;
      7'h73:   return 2;
      7'h64:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic drive_bits(input logic v, input int n);
    entrada_serial = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [6:0] c, input bit flip_par, input bit stop2_bad);
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 7; i++) drive_bits(c[i], CPB);
    drive_bits((^c) ^ flip_par, CPB);
    drive_bits(1'b1, CPB);
    drive_bits(stop2_bad ? 1'b0 : 1'b1, CPB);
  endtask

  task automatic compare_counts(input string tag, input int base[7], input int e[7]);
    for (int k = 0; k < 7; k++)
      check_eq($sformatf("%s.%s", tag, nm[k]), cnt[k] - base[k], e[k]);
  endtask

  task automatic compare_levels(input string tag);
    check_eq({tag, ".dado"}, dado, m_dado);
    check_eq({tag, ".direction"}, direction, m_dir);
    check_eq({tag, ".pause"}, pause, m_pause);
  endtask

  // Send one frame, derive the expected reaction from the character rules,
  // update the model and compare pulses, levels and the final FSM state.
  task automatic run_frame(input string tag, input logic [6:0] c, input bit flip_par,
                           input bit stop2_bad);
    int  base[7];
    int  e[7];
    bit  good;
    int  d;
    base = cnt;
    d    = dir_of(c);
    good = !flip_par && !stop2_bad;
    e[0] = int'(good);
    e[1] = int'(!stop2_bad && flip_par);
    e[2] = int'(stop2_bad);
    e[3] = int'(good && c == 7'h49);
    e[4] = int'(good && c == 7'h52);
    e[5] = int'(good && d >= 0);
    e[6] = int'(good && d < 0 && c != 7'h49 && c != 7'h52 && c != 7'h50);
    send_frame(c, flip_par, stop2_bad);
    if (stop2_bad) begin
      drive_bits(1'b0, 3 * CPB);
      drive_bits(1'b1, CPB - 10);
      check_eq({tag, ".state_hold"}, db_state, 4'd7);
      drive_bits(1'b1, 30);
      check_eq({tag, ".state_exit"}, db_state, 4'd0);
    end else begin
      check_eq({tag, ".state"}, db_state, 4'd0);
    end
    if (good) begin
      m_dado = c;
      if (c == 7'h50) m_pause = ~m_pause;
      if (d >= 0) m_dir = 2'(d);
    end
    compare_counts(tag, base, e);
    compare_levels(tag);
  endtask

  initial begin
    int         base[7];
    int         zero[7];
    logic [6:0] table_c[10];
    zero    = '{0, 0, 0, 0, 0, 0, 0};
    table_c = '{7'h49, 7'h52, 7'h50, 7'h77, 7'h61, 7'h73, 7'h64, 7'h78, 7'h57, 7'h71};

    // Reset values
    repeat (5) @(negedge clock);
    compare_levels("rst");
    check_eq("rst.db_state", db_state, 4'd0);
    check_eq("rst.pulses", prev_p, 7'd0);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check_eq("idle.db_state", db_state, 4'd0);

    run_frame("d", 7'h64, 1'b0, 1'b0);
    run_frame("P1", 7'h50, 1'b0, 1'b0);
    check_eq("P1.pause_on", pause, 1'b1);
    run_frame("P2", 7'h50, 1'b0, 1'b0);
    check_eq("P2.pause_off", pause, 1'b0);
    run_frame("I", 7'h49, 1'b0, 1'b0);
    run_frame("R_badpar", 7'h52, 1'b1, 1'b0);
    check_eq("R_badpar.dado_hold", dado, 7'h49);
    run_frame("w_badstop", 7'h77, 1'b0, 1'b1);
    run_frame("a", 7'h61, 1'b0, 1'b0);

    // Low glitch shorter than half a bit: false start
    base = cnt;
    drive_bits(1'b0, 100);
    drive_bits(1'b1, CPB);
    compare_counts("glitch", base, zero);
    check_eq("glitch.db_state", db_state, 4'd0);

    // Back-to-back frames, then an unknown character
    base = cnt;
    run_frame("a_b2b", 7'h61, 1'b0, 1'b0);
    run_frame("s_b2b", 7'h73, 1'b0, 1'b0);
    check_eq("b2b.dir_valid_total", cnt[5] - base[5], 2);
    check_eq("b2b.direction", direction, 2'b10);
    run_frame("x", 7'h78, 1'b0, 1'b0);

    // Randomized characters, idle gaps and parity faults
    for (int i = 0; i < 3; i++) begin
      drive_bits(1'b1, $urandom_range(1, 60));
      run_frame($sformatf("rnd%0d", i), table_c[$urandom_range(0, 9)],
                ($urandom_range(0, 3) == 0), 1'b0);
    end

    // Reset in the middle of the data bits of 'I'
    base = cnt;
    drive_bits(1'b0, CPB);
    drive_bits(1'b1, CPB);
    drive_bits(1'b0, CPB);
    drive_bits(1'b0, CPB);
    check_eq("midrst.in_dados", db_state, 4'd2);
    reset = 1'b0;
    entrada_serial = 1'b1;
    repeat (5) @(negedge clock);
    m_dado  = '0;
    m_dir   = '0;
    m_pause = 1'b0;
    compare_levels("midrst");
    check_eq("midrst.db_state", db_state, 4'd0);
    check_eq("midrst.pulses", prev_p, 7'd0);
    reset = 1'b1;
    drive_bits(1'b1, CPB);
    compare_counts("midrst", base, zero);
    run_frame("I_after_rst", 7'h49, 1'b0, 1'b0);

    check_eq("pulse_width", n_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
